micro_cmd_issuer: RTL

// - Initiator side of the gpio command protocol that file_register decodes.
// - Accepts one command and its data per handshake from host logic (MicroBlaze shim, UART parser or test sequencer).
// - Drives the 32-bit gpo word {CMD, ENABLE, DATA} with a setup/strobe/hold enable pulse.
// - For read commands, samples the returned gpi word and presents it on a response handshake.

---
 rtl/file_register_pkg.sv | 25 ++
 rtl/micro_cmd_issuer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/file_register_pkg.sv
// Shared definitions for the gpio command protocol spoken between the
// micro-side issuer and file_register.
package file_register_pkg;

    localparam int CMD_W      = 8;
    localparam int DATA_W     = 24;
    localparam int INST_W     = CMD_W + DATA_W;
    localparam int ENABLE_IDX = DATA_W - 1;

    localparam logic [CMD_W-1:0] KERNEL_SEL     = 8'h00;
    localparam logic [CMD_W-1:0] LOAD_FRAME     = 8'h01;
    localparam logic [CMD_W-1:0] END_FRAME      = 8'h02;
    localparam logic [CMD_W-1:0] IS_FRAME_READY = 8'h03;
    localparam logic [CMD_W-1:0] GET_FRAME      = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5
    } issuer_state_t;

endpackage

// File: rtl/micro_cmd_issuer.sv
// Drives {CMD, ENABLE, DATA} onto gpo with a setup/strobe/hold enable pulse
// and, for read commands, returns the sampled gpi word on a response handshake.
module micro_cmd_issuer
    import file_register_pkg::*;
#(
    parameter int NB_C0M     = CMD_W,
    parameter int NB_DATA    = DATA_W,
    parameter int NB_INST    = INST_W,
    parameter int NB_CNT     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1,
    parameter int RSP_WAIT   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [NB_C0M-1:0]  i_req_cmd,
    input  logic [NB_DATA-2:0] i_req_data,
    output logic [NB_INST-1:0] o_gpo,
    input  logic [NB_INST-1:0] i_gpi,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NB_INST-1:0] o_rsp_data,
    output logic               o_busy
);

    issuer_state_t      state_r, state_s;
    logic [NB_CNT-1:0]  cnt_r, cnt_s;
    logic [NB_C0M-1:0]  cmd_r, cmd_s;
    logic [NB_DATA-2:0] data_r, data_s;
    logic [NB_INST-1:0] gpo_r, gpo_s;
    logic               rsp_valid_r, rsp_valid_s;
    logic [NB_INST-1:0] rsp_data_r, rsp_data_s;
    logic               is_read_s;
    logic               cnt_done_s;

    // Read commands are the only ones that expect a gpi word back.
    always_comb begin
        is_read_s  = (cmd_r == NB_C0M'(IS_FRAME_READY)) || (cmd_r == NB_C0M'(GET_FRAME));
        cnt_done_s = (cnt_r == {NB_CNT{1'b0}});
    end

    // Next-state, phase counter and next registered output values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        cmd_s       = cmd_r;
        data_s      = data_r;
        gpo_s       = gpo_r;
        rsp_valid_s = rsp_valid_r;
        rsp_data_s  = rsp_data_r;
        case (state_r)
            ST_IDLE: begin
                if (i_req_valid) begin
                    cmd_s   = i_req_cmd;
                    data_s  = i_req_data;
                    gpo_s   = {i_req_cmd, 1'b0, i_req_data};
                    cnt_s   = NB_CNT'(SETUP_CYC - 1);
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_done_s) begin
                    gpo_s   = {cmd_r, 1'b1, data_r};
                    cnt_s   = NB_CNT'(STROBE_CYC - 1);
                    state_s = ST_STROBE;
                end else begin
                    cnt_s = cnt_r - NB_CNT'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_done_s) begin
                    gpo_s   = {cmd_r, 1'b0, data_r};
                    cnt_s   = NB_CNT'(HOLD_CYC - 1);
                    state_s = ST_HOLD;
                end else begin
                    cnt_s = cnt_r - NB_CNT'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_done_s) begin
                    if (is_read_s) begin
                        cnt_s   = NB_CNT'(RSP_WAIT - 1);
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - NB_CNT'(1);
                end
            end
            ST_CAPTURE: begin
                if (cnt_done_s) begin
                    rsp_data_s  = i_gpi;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else begin
                    cnt_s = cnt_r - NB_CNT'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                gpo_s       = {NB_INST{1'b0}};
                rsp_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears ENABLE immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {NB_CNT{1'b0}};
            cmd_r       <= {NB_C0M{1'b0}};
            data_r      <= {(NB_DATA-1){1'b0}};
            gpo_r       <= {NB_INST{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {NB_INST{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cmd_r       <= cmd_s;
            data_r      <= data_s;
            gpo_r       <= gpo_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
        end
    end

    // Handshake flags decode straight from the state register.
    always_comb begin
        o_req_ready = (state_r == ST_IDLE);
        o_busy      = (state_r != ST_IDLE);
        o_gpo       = gpo_r;
        o_rsp_valid = rsp_valid_r;
        o_rsp_data  = rsp_data_r;
    end

endmodule
